// File: rtl/regs_wr_arb.sv
// Round-robin arbiter sharing one 8-bit register-file write port among three
// requesters; wide requests become a lo/hi register-pair write.
module regs_wr_arb (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [2:0]  wide,
  input  logic [2:0]  addr0,
  input  logic [2:0]  addr1,
  input  logic [2:0]  addr2,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  output logic [2:0]  ack,
  output logic        busy,
  output logic        we,
  output logic [2:0]  waddr,
  output logic [7:0]  d8
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WR_LO = 2'd1;
  localparam logic [1:0] WR_HI = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic        wide_q, wide_d;
  logic [2:0]  addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic        we_q, we_d;
  logic        busy_q, busy_d;
  logic [2:0]  ack_q, ack_d;
  logic [2:0]  waddr_q, waddr_d;
  logic [7:0]  d8_q, d8_d;

  logic [2:0]  masked;
  logic        arb_ok;
  logic        win_vld;
  logic [1:0]  win, c1, c2, c3;
  logic [2:0]  win_addr;
  logic [15:0] win_data;
  logic        win_wide;

  function automatic logic [1:0] rr_idx(input logic [1:0] p, input logic [1:0] k);
    logic [2:0] s;
    s = {1'b0, p} + {1'b0, k};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] i);
    return 3'b001 << i;
  endfunction

  always_comb begin
    // A requester whose ack is on the bus this cycle is finishing; don't regrant it.
    masked = req & ~ack_q;
    arb_ok = (state_q == IDLE) || (state_q == WR_HI) || (state_q == WR_LO && !wide_q);

    c1 = rr_idx(ptr_q, 2'd1);
    c2 = rr_idx(ptr_q, 2'd2);
    c3 = rr_idx(ptr_q, 2'd3);
    win_vld = 1'b0;
    win     = c1;
    if (masked[c3]) begin win_vld = 1'b1; win = c3; end
    if (masked[c2]) begin win_vld = 1'b1; win = c2; end
    if (masked[c1]) begin win_vld = 1'b1; win = c1; end

    case (win)
      2'd0:    begin win_addr = addr0; win_data = data0; end
      2'd1:    begin win_addr = addr1; win_data = data1; end
      default: begin win_addr = addr2; win_data = data2; end
    endcase
    win_wide = wide[win];
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wide_d  = wide_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    busy_d  = 1'b0;
    ack_d   = 3'b000;
    waddr_d = waddr_q;
    d8_d    = d8_q;

    if (state_q == WR_LO && wide_q) begin
      state_d = WR_HI;
      we_d    = 1'b1;
      busy_d  = 1'b1;
      waddr_d = {addr_q[2:1], 1'b1};
      d8_d    = data_q[15:8];
      ack_d   = onehot(ptr_q);
    end else if (arb_ok && win_vld) begin
      state_d = WR_LO;
      ptr_d   = win;
      wide_d  = win_wide;
      addr_d  = win_addr;
      data_d  = win_data;
      we_d    = 1'b1;
      busy_d  = 1'b1;
      waddr_d = win_wide ? {win_addr[2:1], 1'b0} : win_addr;
      d8_d    = win_data[7:0];
      ack_d   = win_wide ? 3'b000 : onehot(win);
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 2'd2;
      wide_q  <= 1'b0;
      addr_q  <= 3'd0;
      data_q  <= 16'd0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= 3'b000;
      waddr_q <= 3'd0;
      d8_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      wide_q  <= wide_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      waddr_q <= waddr_d;
      d8_q    <= d8_d;
    end
  end

  assign ack   = ack_q;
  assign busy  = busy_q;
  assign we    = we_q;
  assign waddr = waddr_q;
  assign d8    = d8_q;

endmodule

// File: tb/tb_regs_wr_arb.sv
// Bench for regs_wr_arb: directed scenarios plus random requesters, checked
// against a transaction-level model that queues pending byte writes.
module tb_regs_wr_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req, wide, addr0, addr1, addr2;
  logic [15:0] data0, data1, data2;
  logic [2:0]  ack, waddr;
  logic        busy, we;
  logic [7:0]  d8;

  regs_wr_arb dut (
    .clk(clk), .reset(reset), .req(req), .wide(wide),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .data0(data0), .data1(data1), .data2(data2),
    .ack(ack), .busy(busy), .we(we), .waddr(waddr), .d8(d8)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: a grant expands into a list of byte writes; the list drains one per cycle.
  typedef struct {
    logic [2:0] a;
    logic [7:0] d;
    logic [2:0] ak;
    int         own;
  } wr_t;

  wr_t        q[$];
  int         last = 2;
  int         e_own = -1;
  logic       e_we = 0, e_busy = 0;
  logic [2:0] e_waddr = 0, e_ack = 0;
  logic [7:0] e_d8 = 0;

  function automatic logic [2:0] in_addr(input int n);
    return (n == 0) ? addr0 : (n == 1) ? addr1 : addr2;
  endfunction

  function automatic logic [15:0] in_data(input int n);
    return (n == 0) ? data0 : (n == 1) ? data1 : data2;
  endfunction

  task automatic model_step();
    logic [2:0] m;
    bit found;
    wr_t w;
    if (reset) begin
      q.delete();
      last = 2; e_own = -1;
      e_we = 0; e_busy = 0; e_waddr = 0; e_ack = 0; e_d8 = 0;
      return;
    end
    if (q.size() == 0) begin
      m = req & ~e_ack;
      found = 0;
      for (int k = 1; k <= 3; k++) begin
        int i;
        i = (last + k) % 3;
        if (!found && m[i]) begin
          logic [2:0]  a;
          logic [15:0] d;
          found = 1;
          last = i;
          a = in_addr(i);
          d = in_data(i);
          if (wide[i]) begin
            q.push_back('{a: a & 3'b110, d: d[7:0],  ak: 3'b000,            own: i});
            q.push_back('{a: a | 3'b001, d: d[15:8], ak: 3'(1 << i),        own: i});
          end else begin
            q.push_back('{a: a,          d: d[7:0],  ak: 3'(1 << i),        own: i});
          end
        end
      end
    end
    if (q.size() > 0) begin
      w = q.pop_front();
      e_we = 1; e_busy = 1; e_waddr = w.a; e_d8 = w.d; e_ack = w.ak; e_own = w.own;
    end else begin
      e_we = 0; e_busy = 0; e_ack = 0; e_own = -1;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("we", 32'(we), 32'(e_we));
    chk("waddr", 32'(waddr), 32'(e_waddr));
    chk("d8", 32'(d8), 32'(e_d8));
    chk("ack", 32'(ack), 32'(e_ack));
    chk("busy", 32'(busy), 32'(e_busy));
  endtask

  task automatic set_in(input int n, input logic r, input logic w,
                        input logic [2:0] a, input logic [15:0] d);
    req[n]  = r;
    wide[n] = w;
    case (n)
      0: begin addr0 = a; data0 = d; end
      1: begin addr1 = a; data1 = d; end
      default: begin addr2 = a; data2 = d; end
    endcase
  endtask

  task automatic do_reset();
    reset = 1; req = 0; wide = 0;
    cycle();
    chk("rst_we", 32'(we), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_waddr", 32'(waddr), 0);
    chk("rst_d8", 32'(d8), 0);
    reset = 0;
  endtask

  bit         act[3];
  logic       a_wide[3];
  logic [2:0] a_addr[3];
  logic [15:0] a_data[3];

  initial begin
    reset = 1; req = 0; wide = 0;
    addr0 = 0; addr1 = 0; addr2 = 0; data0 = 0; data1 = 0; data2 = 0;
    do_reset();

    // Narrow write
    req = 3'b001; addr0 = 3'd5; data0 = 16'h00AA;
    cycle();
    chk("nar_we", 32'(we), 1); chk("nar_waddr", 32'(waddr), 5);
    chk("nar_d8", 32'(d8), 32'hAA); chk("nar_ack", 32'(ack), 1);
    req = 0;
    cycle();
    chk("nar_we_off", 32'(we), 0); chk("nar_hold", 32'(waddr), 5);

    // Wide write
    req = 3'b010; wide = 3'b010; addr1 = 3'd3; data1 = 16'h55AA;
    cycle();
    chk("wide_lo_waddr", 32'(waddr), 2); chk("wide_lo_d8", 32'(d8), 32'hAA);
    chk("wide_lo_ack", 32'(ack), 0);
    cycle();
    chk("wide_hi_waddr", 32'(waddr), 3); chk("wide_hi_d8", 32'(d8), 32'h55);
    chk("wide_hi_ack", 32'(ack), 2);
    req = 0; wide = 0;
    cycle();

    // Contention: order 0,1,2 back to back
    do_reset();
    req = 3'b111;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("rr_we", 32'(we), 1);
      chk("rr_ack", 32'(ack), 32'(1 << k));
      req[k] = 1'b0;
    end

    // Fairness between 0 and 1
    do_reset();
    req = 3'b011;
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("fair_ack", 32'(ack), (k % 2 == 0) ? 1 : 2);
    end
    req = 0;

    // Reset during WR_LO of a wide grant
    do_reset();
    req = 3'b100; wide = 3'b100; addr2 = 3'd7; data2 = 16'hBEEF;
    cycle();
    chk("abort_lo_we", 32'(we), 1); chk("abort_lo_waddr", 32'(waddr), 6);
    reset = 1;
    cycle();
    chk("abort_we", 32'(we), 0); chk("abort_ack", 32'(ack), 0); chk("abort_busy", 32'(busy), 0);
    reset = 0;
    cycle();
    chk("restart_we", 32'(we), 1); chk("restart_ack", 32'(ack), 0);
    chk("restart_d8", 32'(d8), 32'hEF);
    cycle();
    chk("restart_hi_waddr", 32'(waddr), 7); chk("restart_hi_d8", 32'(d8), 32'hBE);
    chk("restart_hi_ack", 32'(ack), 4);
    req = 0; wide = 0;
    cycle();

    // Requester 0 withdraws and scrambles inputs mid wide grant
    do_reset();
    req = 3'b001; wide = 3'b001; addr0 = 3'd4; data0 = 16'h1234;
    cycle();
    chk("drop_lo_waddr", 32'(waddr), 4); chk("drop_lo_d8", 32'(d8), 32'h34);
    req = 0; wide = 0; addr0 = 3'd1; data0 = 16'hFFFF;
    cycle();
    chk("drop_hi_we", 32'(we), 1); chk("drop_hi_waddr", 32'(waddr), 5);
    chk("drop_hi_d8", 32'(d8), 32'h12); chk("drop_hi_ack", 32'(ack), 1);
    cycle();
    chk("drop_once_ack", 32'(ack), 0); chk("drop_we_off", 32'(we), 0);

    // Random requesters
    do_reset();
    for (int n = 0; n < 3; n++) act[n] = 0;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(63) == 0);
      for (int n = 0; n < 3; n++) begin
        if (e_ack[n]) act[n] = 0;
        if (!act[n] && $urandom_range(2) == 0) begin
          act[n] = 1;
          a_wide[n] = 1'($urandom);
          a_addr[n] = 3'($urandom);
          a_data[n] = 16'($urandom);
        end
        if (e_own == n && e_busy && e_ack[n] == 0 && $urandom_range(1) == 1)
          set_in(n, 1'b0, 1'($urandom), 3'($urandom), 16'($urandom));
        else
          set_in(n, act[n], a_wide[n], a_addr[n], a_data[n]);
      end
      cycle();
      if (reset) for (int n = 0; n < 3; n++) act[n] = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regs_wr_arb.md
REGS_WR_ARB -- requirements
Module: regs_wr_arb

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Port req  input  3  write request, bit n for requester n.
REQ-005 Port wide  input  3  bit n set: requester n requests a 16-bit register-pair write.
REQ-006 Port addr0, addr1, addr2  input  3 each  target register address for requesters 0-2.
REQ-007 Port data0, data1, data2  input  16 each  write data; narrow writes use only [7:0].
REQ-008 Port ack  output  3  one-cycle completion pulse, bit n for requester n.
REQ-009 Port busy  output  1  high when a grant is in progress.
REQ-010 Port we  output  1  register-file write enable (drives wea).
REQ-011 Port waddr  output  3  register-file write address.
REQ-012 Port d8  output  8  register-file write data.

Function
REQ-013 The block SHALL time-share the single register-file write port among 3 requesters.
REQ-014 Requester n SHALL hold req[n], wide[n], addrn and datan stable until it sees ack[n].
REQ-015 The block SHALL latch the winner's wide, address and data at grant; later input changes SHALL be ignored until that grant ends.
REQ-016 The FSM SHALL have exactly three states: IDLE, WR_LO and WR_HI.
REQ-017 Arbitration SHALL occur at any edge where the state is IDLE, or is WR_LO for a narrow grant, or is WR_HI.
REQ-018 Arbitration SHALL mask any requester whose ack is high during that cycle.
REQ-019 Priority SHALL be round-robin: last granted index +1, then +2, then the last granted index itself, all modulo 3.
REQ-020 The pointer SHALL update to the winner index at each grant.
REQ-021 A grant SHALL enter WR_LO; if no unmasked request is present, the next state SHALL be IDLE.
REQ-022 In WR_LO the block SHALL drive we=1 and d8=data[7:0].
REQ-023 In WR_LO, waddr SHALL be addr for a narrow grant and {addr[2:1],0} for a wide grant.
REQ-024 A narrow grant SHALL assert ack in WR_LO and end after that cycle.
REQ-025 A wide grant SHALL go from WR_LO to WR_HI and SHALL NOT assert ack in WR_LO.
REQ-026 In WR_HI the block SHALL drive we=1, waddr={addr[2:1],1} and d8=data[15:8], assert ack, and end after that cycle.
REQ-027 Request-to-write latency SHALL be 1 cycle: req sampled at edge T gives we high in cycle T..T+1.
REQ-028 Back-to-back grants SHALL occur with no idle cycle between them.
REQ-029 In IDLE the block SHALL drive we=0; waddr and d8 SHALL hold their last value.
REQ-030 busy SHALL be 1 in WR_LO and WR_HI and 0 in IDLE.
REQ-031 ack SHALL be one-hot or zero, and an ack bit SHALL only be high while we=1.
REQ-032 If req[n] drops mid-grant, the grant SHALL complete all its writes and still pulse ack[n].
REQ-033 For a wide grant, addr[0] SHALL be ignored.
REQ-034 The we, waddr, d8, ack and busy outputs SHALL be registered, with no combinational path from inputs.

Reset
REQ-035 Reset SHALL force state=IDLE, we=0, ack=0, busy=0, waddr=0, d8=0 and round-robin pointer=2, so that requester 0 wins first.
REQ-036 Reset asserted mid-grant SHALL abort it at that edge, with no further write and no ack.
REQ-037 Reset SHALL have priority over any simultaneous request.

Verification
REQ-038 Narrow write: req=001, addr0=5, data0=00AA -> next cycle we=1, waddr=5, d8=AA, ack=001; following cycle we=0.
REQ-039 Wide write: req=010, wide=010, addr1=3, data1=55AA -> cycle 1: waddr=2, d8=AA, ack=000; cycle 2: waddr=3, d8=55, ack=010.
REQ-040 Contention: req=111 held, each requester drops req after its ack -> grant order 0, 1, 2, with we high for 3 consecutive cycles.
REQ-041 Fairness: req=011 held continuously -> acks alternate 001, 010, 001, 010, ...
REQ-042 Requester 2 wide grant with reset asserted in WR_LO -> next cycle we=0, ack=000, busy=0; then req=100 -> grant restarts in WR_LO.
REQ-043 Requester 0 drops req during the WR_HI of its wide grant -> second write still occurs and ack=001 pulses once.
